if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 130 +++++++++++++
 tb/tb_if_id_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode skid FIFO between the IF and ID stages.
// A DEPTH-entry circular buffer of {instr, pc, pc_plus_4}. The head entry is
// presented combinationally on D_*; a NOP with zero PCs is shown when empty.
// Fetch is stalled only when the buffer is full and not draining this cycle.
// E_flush discards everything and drops that cycle's push and pop.
//
// Optional build macro: IF_ID_PERF_CNT_EN adds the stall_cycles and
// flushed_entries performance counters (absent in the default build).
module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        F_valid,
  input  logic [31:0] F_instr,
  input  logic [31:0] F_pc_current,
  input  logic [31:0] F_pc_plus_4,
  output logic        F_stall_pc,
  input  logic        D_ready,
  input  logic        E_flush,
  output logic        D_valid,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc_plus_4
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flushed_entries
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Entry storage; deliberately not reset, validity comes from count_q.
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic [31:0] pc4_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic full;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign D_valid    = (count_q != '0);
  // A full buffer that is draining this cycle frees a slot, so fetch may push.
  assign F_stall_pc = full & ~(D_valid & D_ready);
  assign push       = F_valid & ~F_stall_pc & ~E_flush;
  assign pop        = D_valid & D_ready & ~E_flush;

  // Present the head entry, or a NOP bubble with zero PCs when empty.
  always_comb begin
    D_instr     = NOP_INSTR;
    D_pc        = '0;
    D_pc_plus_4 = '0;
    if (D_valid) begin
      D_instr     = instr_q[rd_ptr_q];
      D_pc        = pc_q[rd_ptr_q];
      D_pc_plus_4 = pc4_q[rd_ptr_q];
    end
  end

  // Next pointer/count; flush wins over push and pop. DEPTH is a power of two,
  // so pointers wrap naturally at PTR_W bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (E_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the fetched entry at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= F_instr;
      pc_q[wr_ptr_q]    <= F_pc_current;
      pc4_q[wr_ptr_q]   <= F_pc_plus_4;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flushed_entries_q;

  assign stall_cycles    = stall_cycles_q;
  assign flushed_entries = flushed_entries_q;

  // Free-running (wrapping) counts of stalled cycles and discarded entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q    <= '0;
      flushed_entries_q <= '0;
    end else begin
      if (F_stall_pc) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (E_flush)    flushed_entries_q <= flushed_entries_q + 32'(count_q);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: expected head entries are queued when the stimulus
// issues an accepted push; a monitor pops and compares on every decode handshake.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        F_valid;
  logic [31:0] F_instr;
  logic [31:0] F_pc_current;
  logic [31:0] F_pc_plus_4;
  logic        F_stall_pc;
  logic        D_ready;
  logic        E_flush;
  logic        D_valid;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc_plus_4;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flushed_entries;
  logic [31:0] flushed_before;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  entry_t sb[$];
  int checks   = 0;
  int failures = 0;

  if_id_buffer #(.DEPTH(2), .NOP_INSTR(32'h0000_0013)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .F_valid      (F_valid),
    .F_instr      (F_instr),
    .F_pc_current (F_pc_current),
    .F_pc_plus_4  (F_pc_plus_4),
    .F_stall_pc   (F_stall_pc),
    .D_ready      (D_ready),
    .E_flush      (E_flush),
    .D_valid      (D_valid),
    .D_instr      (D_instr),
    .D_pc         (D_pc),
    .D_pc_plus_4  (D_pc_plus_4)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flushed_entries (flushed_entries)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch; the caller states whether it is expected to be accepted.
  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc, input bit accepted);
    F_valid      = 1'b1;
    F_instr      = instr;
    F_pc_current = pc;
    F_pc_plus_4  = pc + 32'd4;
    if (accepted) sb.push_back('{instr: instr, pc: pc, pc4: pc + 32'd4});
  endtask

  // Monitor: on each decode handshake, compare the head against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && D_valid && D_ready && !E_flush) begin
      if (sb.size() == 0) begin
        check("pop_with_empty_scoreboard", D_pc, 32'hFFFF_FFFF);
      end else begin
        entry_t e;
        e = sb.pop_front();
        check("sb_instr", D_instr, e.instr);
        check("sb_pc", D_pc, e.pc);
        check("sb_pc4", D_pc_plus_4, e.pc4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; F_valid = 1'b0; F_instr = '0; F_pc_current = '0;
    F_pc_plus_4 = '0; D_ready = 1'b0; E_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_d_valid", {31'd0, D_valid}, 32'd0);
    check("rst_d_instr", D_instr, 32'h0000_0013);
    check("rst_d_pc", D_pc, 32'd0);
    check("rst_d_pc4", D_pc_plus_4, 32'd0);
    check("rst_stall", {31'd0, F_stall_pc}, 32'd0);
`ifdef IF_ID_PERF_CNT_EN
    check("rst_stall_cycles", stall_cycles, 32'd0);
    check("rst_flushed", flushed_entries, 32'd0);
`endif
    reset_n = 1'b1;
    step();

    // Single instruction, one-cycle latency.
    D_ready = 1'b1;
    fetch(32'h0050_0093, 32'h8000_0000, 1'b1);
    @(negedge clk);
    check("lat_not_yet_valid", {31'd0, D_valid}, 32'd0);
    step();
    F_valid = 1'b0;
    @(negedge clk);
    check("lat_valid", {31'd0, D_valid}, 32'd1);
    step();

    // Fill with decode stalled.
    D_ready = 1'b0;
    fetch(32'h0000_0111, 32'h8000_0000, 1'b1);
    step();
    fetch(32'h0000_0222, 32'h8000_0004, 1'b1);
    @(negedge clk);
    check("fill_one_no_stall", {31'd0, F_stall_pc}, 32'd0);
    step();
    fetch(32'h0000_0333, 32'h8000_0008, 1'b0);
    @(negedge clk);
    check("full_stall", {31'd0, F_stall_pc}, 32'd1);
    check("full_head_pc", D_pc, 32'h8000_0000);
    step();
    @(negedge clk);
    check("full_hold_stall", {31'd0, F_stall_pc}, 32'd1);
    check("full_hold_pc", D_pc, 32'h8000_0000);
    step();

    // Drain while full: fetch is released the same cycle.
    D_ready = 1'b1;
    @(negedge clk);
    check("drain_no_stall", {31'd0, F_stall_pc}, 32'd0);
    step();
    sb.push_back('{instr: 32'h0000_0333, pc: 32'h8000_0008, pc4: 32'h8000_000C});
    F_valid = 1'b0;
    D_ready = 1'b0;
    @(negedge clk);
    check("drain_head_pc", D_pc, 32'h8000_0004);
    check("drain_still_full", {31'd0, F_stall_pc}, 32'd1);
    step();

    // Flush with two entries buffered and a fetch pending.
`ifdef IF_ID_PERF_CNT_EN
    flushed_before = flushed_entries;
`endif
    E_flush = 1'b1;
    fetch(32'h0000_0444, 32'h8000_0010, 1'b0);
    step();
    sb.delete();
    E_flush = 1'b0;
    F_valid = 1'b0;
    @(negedge clk);
    check("flush_d_valid", {31'd0, D_valid}, 32'd0);
    check("flush_d_instr", D_instr, 32'h0000_0013);
    check("flush_stall", {31'd0, F_stall_pc}, 32'd0);
`ifdef IF_ID_PERF_CNT_EN
    check("flush_count", flushed_entries - flushed_before, 32'd2);
`endif
    step();

    // Asynchronous reset mid-cycle with one entry held.
    fetch(32'h0000_0555, 32'h9000_0000, 1'b1);
    step();
    F_valid = 1'b0;
    #1;
    check("pre_rst_valid", {31'd0, D_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, D_valid}, 32'd0);
    check("async_rst_pc", D_pc, 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    D_ready = 1'b1;
    fetch(32'h0000_0666, 32'hA000_0000, 1'b1);
    step();
    F_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'd0, D_valid}, 32'd1);
    check("post_rst_pc", D_pc, 32'hA000_0000);
    step();

    // Streaming across several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      fetch(32'h0000_1000 + 32'(i), 32'hB000_0000 + 32'(4 * i), 1'b1);
      @(negedge clk);
      check("stream_no_stall", {31'd0, F_stall_pc}, 32'd0);
      step();
    end
    F_valid = 1'b0;
    step();
    @(negedge clk);
    check("stream_drained", 32'(sb.size()), 32'd0);
    check("stream_empty", {31'd0, D_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
